pixel_dispatcher: RTL and testbench



---
 rtl/fractal_pkg.sv | 18 +
 rtl/raster_counter.sv | 39 +++
 rtl/pixel_dispatcher.sv | 138 +++++++++++++
 tb/tb_pixel_dispatcher.sv | 328 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fractal_pkg.sv
// Shared constants and job type for the fractal pixel pipeline.
package fractal_pkg;

  localparam int X_SIZE   = 640;
  localparam int Y_SIZE   = 480;
  localparam int X_W      = 10;
  localparam int Y_W      = 9;
  localparam int ITER_W   = 8;
  localparam int MAX_ITER = 255;

  // One job as handed to an iteration engine.
  typedef struct packed {
    logic [X_W-1:0] x;
    logic [Y_W-1:0] y;
    logic           julia;
  } pixel_job_t;

endpackage

// File: rtl/raster_counter.sv
// Raster-order (x,y) position counter; (X_SIZE-1,Y_SIZE-1) wraps to (0,0).
module raster_counter #(
  parameter int X_SIZE = fractal_pkg::X_SIZE,
  parameter int Y_SIZE = fractal_pkg::Y_SIZE
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       adv,
  output logic [fractal_pkg::X_W-1:0] x,
  output logic [fractal_pkg::Y_W-1:0] y,
  output logic                       first,
  output logic                       last
);

  localparam logic [fractal_pkg::X_W-1:0] X_LAST = fractal_pkg::X_W'(X_SIZE - 1);
  localparam logic [fractal_pkg::Y_W-1:0] Y_LAST = fractal_pkg::Y_W'(Y_SIZE - 1);

  // Step one pixel along the raster whenever adv is high.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      x <= '0;
      y <= '0;
    end else if (adv) begin
      if (x == X_LAST) begin
        x <= '0;
        y <= (y == Y_LAST) ? '0 : y + 1'b1;
      end else begin
        x <= x + 1'b1;
      end
    end
  end

  // Frame boundary flags for the current position.
  always_comb begin
    first = (x == '0) && (y == '0);
    last  = (x == X_LAST) && (y == Y_LAST);
  end

endmodule

// File: rtl/pixel_dispatcher.sv
// Round-robin job dispatch to N_ENGINES iteration engines with in-order
// result collection into a single registered valid/ready output stage.
//
// Output handshake: a pixel transfers on a rising edge where out_valid=1
// and out_ready=1. While out_valid=1 and out_ready=0 every out_* signal
// holds; a new result is only loaded when the stage is empty or is being
// emptied in the same cycle.
module pixel_dispatcher #(
  parameter int N_ENGINES = 4,
  parameter int X_SIZE    = fractal_pkg::X_SIZE,
  parameter int Y_SIZE    = fractal_pkg::Y_SIZE,
  parameter int ITER_W    = fractal_pkg::ITER_W
) (
  input  logic                          aclk,
  input  logic                          aresetn,
  input  logic                          ctrl_enable,
  input  logic                          ctrl_julia,
  output logic [N_ENGINES-1:0]          eng_start,
  output logic [fractal_pkg::X_W-1:0]   eng_x,
  output logic [fractal_pkg::Y_W-1:0]   eng_y,
  output logic                          eng_julia,
  input  logic [N_ENGINES-1:0]          eng_done,
  input  logic [N_ENGINES*ITER_W-1:0]   eng_iter,
  output logic [N_ENGINES-1:0]          eng_ack,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [ITER_W-1:0]             out_iter,
  output logic                          out_sof,
  output logic                          out_eol,
  output logic                          status_busy,
  output logic [15:0]                   frame_count
);

  import fractal_pkg::pixel_job_t;

  localparam int PTR_W = (N_ENGINES > 1) ? $clog2(N_ENGINES) : 1;
  localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(N_ENGINES - 1);
  localparam logic [fractal_pkg::X_W-1:0] X_LAST = fractal_pkg::X_W'(X_SIZE - 1);

  logic [N_ENGINES-1:0]        busy;
  logic [N_ENGINES-1:0]        busy_n;
  logic [N_ENGINES-1:0]        idle;
  logic [PTR_W-1:0]            dp;
  logic [PTR_W-1:0]            cp;
  logic                        dispatch;
  logic                        collect;
  logic                        out_valid_n;
  logic                        out_last;
  pixel_job_t                  job;

  logic [fractal_pkg::X_W-1:0] dx;
  logic [fractal_pkg::Y_W-1:0] dy;
  logic [fractal_pkg::X_W-1:0] cx;
  logic [fractal_pkg::Y_W-1:0] cy;
  logic                        c_first;
  logic                        c_last;
  logic                        d_first_unused;
  logic                        d_last_unused;

  raster_counter #(.X_SIZE(X_SIZE), .Y_SIZE(Y_SIZE)) u_dispatch_pos (
    .clk   (aclk),
    .rst_n (aresetn),
    .adv   (dispatch),
    .x     (dx),
    .y     (dy),
    .first (d_first_unused),
    .last  (d_last_unused)
  );

  raster_counter #(.X_SIZE(X_SIZE), .Y_SIZE(Y_SIZE)) u_collect_pos (
    .clk   (aclk),
    .rst_n (aresetn),
    .adv   (collect),
    .x     (cx),
    .y     (cy),
    .first (c_first),
    .last  (c_last)
  );

  // Dispatch/collect decisions; an engine still being acked is not idle, so
  // it cannot be restarted while its eng_done is still falling.
  always_comb begin
    idle        = ~busy & ~eng_ack;
    dispatch    = ctrl_enable && idle[dp];
    collect     = busy[cp] && eng_done[cp] && (!out_valid || out_ready);
    busy_n      = busy;
    if (dispatch) busy_n[dp] = 1'b1;
    if (collect)  busy_n[cp] = 1'b0;
    out_valid_n = collect ? 1'b1 : (out_ready ? 1'b0 : out_valid);
    job.x       = dx;
    job.y       = dy;
    job.julia   = ctrl_julia;
  end

  // Registered engine interface, pointers, output stage and frame counter.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      busy        <= '0;
      dp          <= '0;
      cp          <= '0;
      eng_start   <= '0;
      eng_x       <= '0;
      eng_y       <= '0;
      eng_julia   <= 1'b0;
      eng_ack     <= '0;
      out_valid   <= 1'b0;
      out_iter    <= '0;
      out_sof     <= 1'b0;
      out_eol     <= 1'b0;
      out_last    <= 1'b0;
      status_busy <= 1'b0;
      frame_count <= '0;
    end else begin
      busy        <= busy_n;
      eng_start   <= dispatch ? (N_ENGINES'(1) << dp) : '0;
      eng_ack     <= collect  ? (N_ENGINES'(1) << cp) : '0;
      out_valid   <= out_valid_n;
      status_busy <= (|busy_n) | out_valid_n;
      if (dispatch) begin
        eng_x     <= job.x;
        eng_y     <= job.y;
        eng_julia <= job.julia;
        dp        <= (dp == PTR_LAST) ? '0 : dp + 1'b1;
      end
      if (collect) begin
        out_iter <= eng_iter[cp*ITER_W +: ITER_W];
        out_sof  <= c_first;
        out_eol  <= (cx == X_LAST);
        out_last <= c_last;
        cp       <= (cp == PTR_LAST) ? '0 : cp + 1'b1;
      end
      if (out_valid && out_ready && out_last) begin
        frame_count <= frame_count + 16'd1;
      end
    end
  end

endmodule

// File: tb/tb_pixel_dispatcher.sv
// Bench for pixel_dispatcher on a 4x2 frame with four modelled engines.
module tb_pixel_dispatcher;

  localparam int N  = 4;
  localparam int XS = 4;
  localparam int YS = 2;
  localparam int IW = 8;
  localparam int W  = IW + 2;
  localparam int NPIX = XS * YS;

  // ---------------- clock / reset ----------------
  logic aclk    = 1'b0;
  logic aresetn = 1'b0;
  always #5 aclk = ~aclk;

  logic              ctrl_enable;
  logic              ctrl_julia = 1'b0;
  logic [N-1:0]      eng_start;
  logic [9:0]        eng_x;
  logic [8:0]        eng_y;
  logic              eng_julia;
  logic [N-1:0]      eng_done = '0;
  logic [N*IW-1:0]   eng_iter;
  logic [N-1:0]      eng_ack;
  logic              out_valid;
  logic              out_ready = 1'b1;
  logic [IW-1:0]     out_iter;
  logic              out_sof;
  logic              out_eol;
  logic              status_busy;
  logic [15:0]       frame_count;

  pixel_dispatcher #(.N_ENGINES(N), .X_SIZE(XS), .Y_SIZE(YS), .ITER_W(IW)) dut (
    .aclk        (aclk),
    .aresetn     (aresetn),
    .ctrl_enable (ctrl_enable),
    .ctrl_julia  (ctrl_julia),
    .eng_start   (eng_start),
    .eng_x       (eng_x),
    .eng_y       (eng_y),
    .eng_julia   (eng_julia),
    .eng_done    (eng_done),
    .eng_iter    (eng_iter),
    .eng_ack     (eng_ack),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_iter    (out_iter),
    .out_sof     (out_sof),
    .out_eol     (out_eol),
    .status_busy (status_busy),
    .frame_count (frame_count)
  );

  // ---------------- bookkeeping ----------------
  int n_checks = 0;
  int n_pass   = 0;
  int n_fail   = 0;

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act == exp) n_pass++;
    else begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Dispatch budget: enable is held only until disp_cnt reaches disp_limit.
  int disp_cnt   = 0;
  int disp_limit = 0;
  assign ctrl_enable = (disp_cnt < disp_limit);

  logic julia_smp = 1'b0;
  always @(posedge aclk) julia_smp <= ctrl_julia;

  // ---------------- engine model ----------------
  int            lat [N];
  int            cnt [N];
  logic          eb  [N];
  logic [IW-1:0] iter_r [N];
  int            base = 0;
  int            exp_idx = 0;
  int            ack_ptr = 0;
  logic          jul_seen [NPIX];

  always_comb begin
    for (int i = 0; i < N; i++) eng_iter[i*IW +: IW] = iter_r[i];
  end

  initial begin
    for (int i = 0; i < N; i++) begin
      lat[i] = 2; cnt[i] = 0; eb[i] = 1'b0; iter_r[i] = '0;
    end
    for (int i = 0; i < NPIX; i++) jul_seen[i] = 1'b0;
  end

  always @(negedge aclk) begin
    if (!aresetn) begin
      eng_done = '0;
      for (int i = 0; i < N; i++) begin eb[i] = 1'b0; cnt[i] = 0; end
      exp_idx = 0;
      ack_ptr = 0;
    end else begin
      if (eng_ack != '0) begin
        check("ack_order", int'(eng_ack), 1 << ack_ptr);
        ack_ptr = (ack_ptr + 1) % N;
      end
      if (eng_start != '0) begin
        check("start_onehot", $countones(eng_start), 1);
        check("eng_x", int'(eng_x), exp_idx % XS);
        check("eng_y", int'(eng_y), exp_idx / XS);
        check("eng_julia", int'(eng_julia), int'(julia_smp));
        jul_seen[exp_idx] = eng_julia;
        exp_idx = (exp_idx + 1) % NPIX;
        disp_cnt++;
      end
      for (int i = 0; i < N; i++) begin
        if (eng_ack[i]) begin
          eng_done[i] = 1'b0;
          eb[i] = 1'b0;
        end
        if (eng_start[i]) begin
          check("no_restart_before_ack", int'(eb[i]), 0);
          eb[i]     = 1'b1;
          cnt[i]    = lat[i];
          iter_r[i] = IW'(base + int'(eng_x) + XS * int'(eng_y));
        end else if (eb[i] && !eng_done[i] && cnt[i] > 0) begin
          cnt[i]--;
          if (cnt[i] == 0) eng_done[i] = 1'b1;
        end
      end
    end
  end

  // ---------------- scoreboard ----------------
  logic [W-1:0] exp_q [$];

  always @(negedge aclk) begin
    if (aresetn && out_valid && out_ready) begin
      if (exp_q.size() == 0) check("unexpected_output", 1, 0);
      else begin
        logic [W-1:0] e;
        e = exp_q.pop_front();
        check("out_iter", int'(out_iter), int'(e[IW-1:0]));
        check("out_sof",  int'(out_sof),  int'(e[IW]));
        check("out_eol",  int'(out_eol),  int'(e[IW+1]));
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick(input int n);
    repeat (n) @(posedge aclk);
    #1;
  endtask

  // Expected pixels for raster indices first..first+n-1: iter = b + index.
  task automatic push_range(input int first, input int n, input int b);
    for (int k = 0; k < n; k++) begin
      logic [W-1:0] e;
      int idx;
      idx = (first + k) % NPIX;
      e[IW-1:0] = IW'(b + idx);
      e[IW]     = (idx == 0);
      e[IW+1]   = ((idx % XS) == XS - 1);
      exp_q.push_back(e);
    end
  endtask

  task automatic set_lat(input int l0, input int l1, input int l2, input int l3);
    lat[0] = l0; lat[1] = l1; lat[2] = l2; lat[3] = l3;
  endtask

  task automatic wait_drain(input string name);
    int c;
    c = 0;
    while ((exp_q.size() != 0 || status_busy) && c < 300) begin
      tick(1);
      c++;
    end
    check({name, "_drain_in_time"}, int'(c < 300), 1);
  endtask

  task automatic wait_dispatched(input string name);
    int c;
    c = 0;
    while (disp_cnt < disp_limit && c < 100) begin
      tick(1);
      c++;
    end
    check({name, "_dispatch_in_time"}, int'(c < 100), 1);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    tick(3);
    check("rst_eng_start", int'(eng_start), 0);
    check("rst_eng_x", int'(eng_x), 0);
    check("rst_eng_y", int'(eng_y), 0);
    check("rst_eng_julia", int'(eng_julia), 0);
    check("rst_eng_ack", int'(eng_ack), 0);
    check("rst_out_valid", int'(out_valid), 0);
    check("rst_out_iter", int'(out_iter), 0);
    check("rst_out_sof", int'(out_sof), 0);
    check("rst_out_eol", int'(out_eol), 0);
    check("rst_status_busy", int'(status_busy), 0);
    check("rst_frame_count", int'(frame_count), 0);
    aresetn = 1'b1;
    tick(1);

    // Fixed 2-cycle engines, full frame, downstream always ready.
    set_lat(2, 2, 2, 2);
    base = 0;
    push_range(0, NPIX, 0);
    disp_limit += NPIX;
    wait_drain("t1");
    check("t1_frame_count", int'(frame_count), 1);

    // Uneven latencies: engine 1 finishes first, order must stay raster.
    set_lat(7, 1, 3, 2);
    base = 16;
    push_range(0, NPIX, 16);
    disp_limit += NPIX;
    wait_drain("t2");
    check("t2_frame_count", int'(frame_count), 2);

    // Downstream stall for 5 cycles with a result held in the output stage.
    set_lat(2, 2, 2, 2);
    base = 32;
    out_ready = 1'b0;
    push_range(0, NPIX, 32);
    disp_limit += NPIX;
    begin
      int c;
      c = 0;
      while (!out_valid && c < 50) begin tick(1); c++; end
      check("t3_valid_in_time", int'(c < 50), 1);
    end
    tick(1);
    for (int k = 0; k < 5; k++) begin
      check("t3_hold_valid", int'(out_valid), 1);
      check("t3_hold_iter", int'(out_iter), 32);
      check("t3_hold_no_ack", int'(eng_ack), 0);
      tick(1);
    end
    out_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      check("t3_stream_valid", int'(out_valid), 1);
      tick(1);
    end
    wait_drain("t3");
    check("t3_frame_count", int'(frame_count), 3);

    // Enable withdrawn after 3 dispatches, then resumed.
    base = 48;
    push_range(0, 3, 48);
    disp_limit += 3;
    wait_drain("t4a");
    tick(5);
    check("t4_idle_busy", int'(status_busy), 0);
    check("t4_idle_valid", int'(out_valid), 0);
    check("t4_idle_starts", disp_cnt, disp_limit);
    push_range(3, NPIX - 3, 48);
    disp_limit += NPIX - 3;
    begin
      int c;
      c = 0;
      while (eng_start == '0 && c < 20) begin tick(1); c++; end
      check("t4_resume_in_time", int'(c < 20), 1);
      check("t4_resume_x", int'(eng_x), 3);
      check("t4_resume_y", int'(eng_y), 0);
    end
    wait_drain("t4b");
    check("t4_frame_count", int'(frame_count), 4);

    // Julia bit changes between dispatch 2 and dispatch 3.
    base = 64;
    ctrl_julia = 1'b0;
    push_range(0, NPIX, 64);
    disp_limit += 2;
    wait_dispatched("t5a");
    ctrl_julia = 1'b1;
    disp_limit += NPIX - 2;
    wait_drain("t5");
    check("t5_julia_job1", int'(jul_seen[1]), 0);
    check("t5_julia_job2", int'(jul_seen[2]), 1);
    check("t5_julia_job7", int'(jul_seen[7]), 1);
    check("t5_frame_count", int'(frame_count), 5);
    ctrl_julia = 1'b0;

    // Reset mid-frame with four long jobs in flight.
    set_lat(10, 10, 10, 10);
    base = 80;
    disp_limit += 4;
    wait_dispatched("t6a");
    tick(1);
    check("t6_busy_before_rst", int'(status_busy), 1);
    aresetn = 1'b0;
    #1;
    check("t6_rst_eng_start", int'(eng_start), 0);
    check("t6_rst_eng_ack", int'(eng_ack), 0);
    check("t6_rst_eng_x", int'(eng_x), 0);
    check("t6_rst_out_valid", int'(out_valid), 0);
    check("t6_rst_status_busy", int'(status_busy), 0);
    check("t6_rst_frame_count", int'(frame_count), 0);
    exp_q.delete();
    tick(2);
    set_lat(2, 2, 2, 2);
    base = 96;
    push_range(0, NPIX, 96);
    aresetn = 1'b1;
    disp_limit += NPIX;
    wait_drain("t6");
    check("t6_frame_count", int'(frame_count), 1);

    tick(2);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  // Absolute bound on run time.
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog");
  end

endmodule
